// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - instruction fetch/decode stage with redirect handling (option: FETCH_DECODE_PERF_COUNT_EN)
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [5:0]  OPcode,
    output logic [3:0]  Rd,
    output logic [3:0]  Rs1,
    output logic [3:0]  Rs2,
    output logic [15:0] Imm,
    output logic [1:0]  Mode,
    output logic [31:0] PC,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] ir;
    logic [31:0] redirect_pc;
    logic        redirect_pend;
    logic        pend_set, pend_clr;
    logic        capture, present;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        pend_set      = 1'b0;
        pend_clr      = 1'b0;
        capture       = 1'b0;
        present       = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    // A redirect seen during this request makes the returned word stale.
                    if (pc_load || redirect_pend) begin
                        fetch_pc_next = pc_load ? pc_target : redirect_pc;
                        pend_clr      = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        state_next = DECODE;
                    end
                end else if (pc_load) begin
                    pend_set = 1'b1;
                end
            end
            DECODE: begin
                if (pc_load) begin
                    fetch_pc_next = pc_target;
                    state_next    = FETCH;
                end else begin
                    present    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (dec_ready) begin
                    fetch_pc_next = pc_load ? pc_target : fetch_pc + 32'(PC_STEP);
                    state_next    = FETCH;
                end else if (pc_load) begin
                    fetch_pc_next = pc_target;
                    state_next    = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign imem_req  = (state == FETCH) && !reset;
    assign imem_addr = fetch_pc;
    assign dec_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            fetch_pc      <= RESET_PC;
            ir            <= 32'h0;
            redirect_pend <= 1'b0;
            redirect_pc   <= 32'h0;
            OPcode        <= 6'h0;
            Rd            <= 4'h0;
            Rs1           <= 4'h0;
            Rs2           <= 4'h0;
            Imm           <= 16'h0;
            Mode          <= 2'b00;
            PC            <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if (capture) begin
                ir <= imem_data;
            end
            // Later redirects overwrite earlier ones so the last target wins.
            if (pend_set) begin
                redirect_pend <= 1'b1;
                redirect_pc   <= pc_target;
            end else if (pend_clr) begin
                redirect_pend <= 1'b0;
            end
            if (present) begin
                OPcode <= ir[31:26];
                Rd     <= ir[25:22];
                Rs1    <= ir[21:18];
                Rs2    <= ir[17:14];
                Imm    <= ir[17:2];
                Mode   <= ir[1:0];
                PC     <= fetch_pc;
            end
        end
    end

`ifdef FETCH_DECODE_PERF_COUNT_EN
    logic        accept;
    logic [31:0] count_q;

    assign accept = (state == HOLD) && dec_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'h0;
        end else if (accept) begin
            count_q <= count_q + 32'h1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule
